gate_checker: RTL and testbench

Synthesizable response checker for the small combinational gates in this codebase. The checker is the receiving end of gate stimulus. It accepts (input vector, observed output) beats over a valid/ready handshake and compares each observed output against the expected gate function. It tracks which input combinations have been exercised and reports pass/fail once every combination has been seen. It sits between a gate under test and a status register or LED, replacing manual waveform inspection in hardware bring-up.

---
 rtl/gate_checker_if.sv | 24 ++
 rtl/gate_checker.sv | 113 +++++++++++
 tb/tb_gate_checker.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_checker_if.sv
// Beat channel between a gate under test and gate_checker.
// master drives vector/observation; slave returns ready.
interface gate_checker_if #(
  parameter int N_IN = 2
);
  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] in_vec;
  logic            out_obs;

  modport master (
    output in_valid,
    output in_vec,
    output out_obs,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_vec,
    input  out_obs,
    output in_ready
  );
endinterface

// File: rtl/gate_checker.sv
// Response checker for small reduction gates: scores beats, tracks coverage.
// Optional GATE_CHECKER_FIRST_ERR_EN keeps the first mismatching vector.
module gate_checker #(
  parameter int N_IN = 2,
  parameter int FUNC = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  gate_checker_if.slave        bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [7:0]           err_count,
  output logic [2**N_IN-1:0]   cover_map,
  output logic [N_IN-1:0]      first_err_vec
);

  localparam int NV = 2**N_IN;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic            rdy;
  logic            exp_o;
  logic            fire;
  logic            mis;
  logic [7:0]      err_nxt;
  logic [NV-1:0]   cov_nxt;

  assign bus.in_ready = rdy;

  always_comb begin
    exp_o = &bus.in_vec;
    case (FUNC)
      1:       exp_o = |bus.in_vec;
      2:       exp_o = ^bus.in_vec;
      3:       exp_o = ~&bus.in_vec;
      4:       exp_o = ~|bus.in_vec;
      5:       exp_o = ~^bus.in_vec;
      default: exp_o = &bus.in_vec;
    endcase
  end

  always_comb begin
    fire    = rdy & bus.in_valid;
    mis     = fire & (bus.out_obs != exp_o);
    err_nxt = err_count;
    cov_nxt = cover_map;
    if (mis && err_count != 8'hff)
      err_nxt = err_count + 8'd1;
    if (fire)
      cov_nxt = cover_map | (NV'(1) << bus.in_vec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdy       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      cover_map <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            rdy       <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            cover_map <= '0;
          end
        end
        RUN: begin
          err_count <= err_nxt;
          cover_map <= cov_nxt;
          // a beat landing with abort is still scored above
          if (abort || (fire && (&cov_nxt))) begin
            state <= DONE;
            rdy   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= ~abort & (&cov_nxt) & (err_nxt == 8'd0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GATE_CHECKER_FIRST_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      first_err_vec <= '0;
    else if (state != RUN && start)
      first_err_vec <= '0;
    else if (mis && err_count == 8'd0)
      first_err_vec <= bus.in_vec;
  end
`else
  assign first_err_vec = '0;
`endif

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: AND and XOR instances share stimulus,
// a coverage/popcount model is checked every cycle plus literal pins.
module tb_gate_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_vec = 2'b00;
  logic       out_obs = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_checker_if #(.N_IN(2)) b0 ();
  gate_checker_if #(.N_IN(2)) b2 ();

  assign b0.in_valid = in_valid;
  assign b0.in_vec   = in_vec;
  assign b0.out_obs  = out_obs;
  assign b2.in_valid = in_valid;
  assign b2.in_vec   = in_vec;
  assign b2.out_obs  = out_obs;

  logic       busy0, done0, pass0, busy2, done2, pass2;
  logic [7:0] err0, err2;
  logic [3:0] cov0, cov2;
  logic [1:0] fev0, fev2;

  gate_checker #(.N_IN(2), .FUNC(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .bus(b0.slave), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .cover_map(cov0), .first_err_vec(fev0)
  );

  gate_checker #(.N_IN(2), .FUNC(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .bus(b2.slave), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .cover_map(cov2), .first_err_vec(fev2)
  );

  // gate value from the count of ones in the vector
  function automatic logic gate_ref(int func, logic [1:0] v);
    int  ones;
    logic r;
    ones = int'(v[0]) + int'(v[1]);
    case (func)
      1:       r = (ones > 0);
      2:       r = (ones % 2) == 1;
      3:       r = !(ones == 2);
      4:       r = !(ones > 0);
      5:       r = !((ones % 2) == 1);
      default: r = (ones == 2);
    endcase
    return r;
  endfunction

  function automatic bit all_seen(logic [3:0] c, logic [1:0] v);
    int n;
    n = 0;
    for (int k = 0; k < 4; k++)
      if (c[k] || k == int'(v)) n++;
    return n == 4;
  endfunction

  function automatic int fn_of(int i);
    return (i == 0) ? 0 : 2;
  endfunction

  bit         m_run[2];
  bit         m_done[2];
  bit         m_pass[2];
  int         m_err[2];
  logic [3:0] m_cov[2];
  logic [1:0] m_fev[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i]  <= 0;
        m_done[i] <= 0;
        m_pass[i] <= 0;
        m_err[i]  <= 0;
        m_cov[i]  <= '0;
        m_fev[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_run[i]) begin
          if (start) begin
            m_run[i]  <= 1;
            m_done[i] <= 0;
            m_pass[i] <= 0;
            m_err[i]  <= 0;
            m_cov[i]  <= '0;
            m_fev[i]  <= '0;
          end
        end else begin
          if (in_valid) begin
            m_cov[i][in_vec] <= 1'b1;
            if (gate_ref(fn_of(i), in_vec) != out_obs) begin
              m_err[i] <= (m_err[i] < 255) ? m_err[i] + 1 : 255;
`ifdef GATE_CHECKER_FIRST_ERR_EN
              if (m_err[i] == 0) m_fev[i] <= in_vec;
`endif
            end
          end
          if (abort || (in_valid && all_seen(m_cov[i], in_vec))) begin
            m_run[i]  <= 0;
            m_done[i] <= 1;
            m_pass[i] <= !abort && all_seen(m_cov[i], in_vec) &&
                         m_err[i] == 0 &&
                         gate_ref(fn_of(i), in_vec) == out_obs;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("rdy0",  int'(b0.in_ready), int'(m_run[0]));
    chk("busy0", int'(busy0), int'(m_run[0]));
    chk("done0", int'(done0), int'(m_done[0]));
    chk("pass0", int'(pass0), int'(m_pass[0]));
    chk("err0",  int'(err0), m_err[0]);
    chk("cov0",  int'(cov0), int'(m_cov[0]));
    chk("fev0",  int'(fev0), int'(m_fev[0]));
    chk("rdy2",  int'(b2.in_ready), int'(m_run[1]));
    chk("busy2", int'(busy2), int'(m_run[1]));
    chk("done2", int'(done2), int'(m_done[1]));
    chk("pass2", int'(pass2), int'(m_pass[1]));
    chk("err2",  int'(err2), m_err[1]);
    chk("cov2",  int'(cov2), int'(m_cov[1]));
    chk("fev2",  int'(fev2), int'(m_fev[1]));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [1:0] v, input logic o);
    in_valid = 1'b1;
    in_vec   = v;
    out_obs  = o;
    tick();
    in_valid = 1'b0;
  endtask

  int fev_exp;

  initial begin
`ifdef GATE_CHECKER_FIRST_ERR_EN
    fev_exp = 1;
`else
    fev_exp = 0;
`endif
    fork
      forever begin
        @(negedge clk);
        compare_all();
      end
    join_none

    tick();
    chk("rst_busy", int'(busy0), 0);
    chk("rst_cov", int'(cov0), 0);
    tick();
    rst_n = 1'b1;

    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("idle_cov", int'(cov0), 0);
    chk("idle_err", int'(err0), 0);

    pulse_start();
    chk("run_rdy", int'(b0.in_ready), 1);
    beat(2'd0, 1'b0);
    beat(2'd1, 1'b0);
    beat(2'd2, 1'b0);
    chk("not_done", int'(done0), 0);
    beat(2'd3, 1'b1);
    chk("t1_done", int'(done0), 1);
    chk("t1_pass", int'(pass0), 1);
    chk("t1_err", int'(err0), 0);
    chk("t1_cov", int'(cov0), 15);
    chk("t1_rdy", int'(b0.in_ready), 0);
    chk("t1_x_err", int'(err2), 3);

    in_valid = 1'b1;
    abort = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    abort = 1'b0;
    chk("done_hold", int'(done0), 1);
    chk("done_err", int'(err0), 0);

    pulse_start();
    beat(2'd0, 1'b0);
    beat(2'd1, 1'b1);
    beat(2'd2, 1'b0);
    beat(2'd3, 1'b1);
    chk("t2_done", int'(done0), 1);
    chk("t2_pass", int'(pass0), 0);
    chk("t2_err", int'(err0), 1);
    chk("t2_fev", int'(fev0), fev_exp);

    pulse_start();
    beat(2'd0, 1'b0);
    beat(2'd0, 1'b0);
    beat(2'd3, 1'b0);
    beat(2'd1, 1'b1);
    chk("t3_pre", int'(done2), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_done", int'(done2), 1);
    chk("t3_pass", int'(pass2), 0);
    chk("t3_cov", int'(cov2), 11);
    chk("t3_err", int'(err2), 0);

    pulse_start();
    for (int n = 0; n < 300; n++) beat(2'd1, 1'b1);
    beat(2'd0, 1'b0);
    beat(2'd2, 1'b0);
    beat(2'd3, 1'b1);
    chk("t4_err", int'(err0), 255);
    chk("t4_done", int'(done0), 1);
    chk("t4_pass", int'(pass0), 0);

    pulse_start();
    beat(2'd0, 1'b0);
    beat(2'd1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_busy", int'(busy0), 0);
    chk("ar_cov", int'(cov0), 0);
    chk("ar_rdy", int'(b0.in_ready), 0);
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", int'(busy0), 1);
    beat(2'd3, 1'b1);
    beat(2'd2, 1'b0);
    beat(2'd1, 1'b0);
    beat(2'd0, 1'b0);
    chk("t5_pass", int'(pass0), 1);
    chk("t5_done", int'(done0), 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
